// File: rtl/lpf_pkg.sv
// Shared sizes, FSM state type and output saturation for the low-pass filter sequencer.
package lpf_pkg;

    localparam int NTAPS = 32;
    localparam int DW    = 22;
    localparam int CW    = 12;
    localparam int OW    = 32;
    localparam int ACCW  = 39;
    localparam int AW    = $clog2(NTAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    // Clamp a full-width accumulator into the signed OW-bit output range.
    function automatic logic signed [OW-1:0] sat_acc(input logic signed [ACCW-1:0] a);
        logic [ACCW-OW:0] top;
        top = a[ACCW-1:OW-1];
        if ((&top) || !(|top)) begin
            sat_acc = $signed(a[OW-1:0]);
        end else if (a[ACCW-1]) begin
            sat_acc = $signed({1'b1, {(OW-1){1'b0}}});
        end else begin
            sat_acc = $signed({1'b0, {(OW-1){1'b1}}});
        end
    endfunction

endpackage

// File: rtl/lpf_mac.sv
// Single signed multiply-accumulate with synchronous clear; one per I/Q channel.
module lpf_mac
    import lpf_pkg::*;
(
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [CW-1:0]   coef,
    input  logic signed [DW-1:0]   sample,
    output logic signed [ACCW-1:0] acc
);

    logic signed [CW+DW-1:0] prod;

    // Full-precision product of coefficient and sample.
    always_comb begin
        prod = (CW+DW)'(coef) * (CW+DW)'(sample);
    end

    // Accumulator: clear on a new sample, add one product per enabled cycle.
    always_ff @(posedge clock) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACCW'(prod);
        end
    end

endmodule

// File: rtl/lpf_seq.sv
// Time-multiplexed 32-tap complex low-pass filter sequencer with coefficient bank.
module lpf_seq
    import lpf_pkg::*;
(
    input  logic          clock,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] sig_baseband_real,
    input  logic [DW-1:0] sig_baseband_imag,
    input  logic          coef_wr_en,
    input  logic [AW-1:0] coef_wr_addr,
    input  logic [CW-1:0] coef_wr_data,
    output logic          coef_wr_err,
    output logic          out_valid,
    output logic [OW-1:0] lpf_output_real,
    output logic [OW-1:0] lpf_output_imag,
    output logic          busy
);

    state_t              state;
    state_t              state_nxt;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       tap;
    logic [AW-1:0]       rd_idx;
    logic [DW-1:0]       smp_i [NTAPS];
    logic [DW-1:0]       smp_q [NTAPS];
    logic [CW-1:0]       coef  [NTAPS];
    logic                accept;
    logic                mac_en;
    logic signed [ACCW-1:0] acc_i;
    logic signed [ACCW-1:0] acc_q;

    // Next-state logic and status decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = (state == IDLE);
        busy      = (state == MAC) || (state == DONE);
        mac_en    = (state == MAC);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (tap == AW'(NTAPS-1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // wr_ptr has already moved past the newest sample, so wr_ptr+0 is the oldest.
    always_comb begin
        rd_idx = wr_ptr + tap;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write pointer and tap counter.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            tap    <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            tap    <= '0;
        end else if (mac_en) begin
            tap <= tap + 1'b1;
        end
    end

    // Circular I/Q sample buffer, written only on acceptance.
    always_ff @(posedge clock) begin
        if (rst) begin
            smp_i <= '{default: '0};
            smp_q <= '{default: '0};
        end else if (accept) begin
            smp_i[wr_ptr] <= sig_baseband_real;
            smp_q[wr_ptr] <= sig_baseband_imag;
        end
    end

    // Coefficient bank: writes land only while idle, otherwise flagged next cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            coef        <= '{default: '0};
            coef_wr_err <= 1'b0;
        end else begin
            coef_wr_err <= coef_wr_en && (state != IDLE);
            if (coef_wr_en && (state == IDLE)) begin
                coef[coef_wr_addr] <= coef_wr_data;
            end
        end
    end

    // Registered, saturated results with a one-cycle valid pulse.
    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid       <= 1'b0;
            lpf_output_real <= '0;
            lpf_output_imag <= '0;
        end else begin
            out_valid <= (state == DONE);
            if (state == DONE) begin
                lpf_output_real <= sat_acc(acc_i);
                lpf_output_imag <= sat_acc(acc_q);
            end
        end
    end

    lpf_mac u_mac_i (
        .clock  (clock),
        .rst    (rst),
        .clr    (accept),
        .en     (mac_en),
        .coef   (coef[tap]),
        .sample (smp_i[rd_idx]),
        .acc    (acc_i)
    );

    lpf_mac u_mac_q (
        .clock  (clock),
        .rst    (rst),
        .clr    (accept),
        .en     (mac_en),
        .coef   (coef[tap]),
        .sample (smp_q[rd_idx]),
        .acc    (acc_q)
    );

endmodule

// File: tb/tb_lpf_seq.sv
// Directed, table-driven bench for lpf_seq.
`timescale 1ns/1ps
module tb_lpf_seq;
    import lpf_pkg::*;

    logic          clock = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] sig_baseband_real;
    logic [DW-1:0] sig_baseband_imag;
    logic          coef_wr_en;
    logic [AW-1:0] coef_wr_addr;
    logic [CW-1:0] coef_wr_data;
    logic          coef_wr_err;
    logic          out_valid;
    logic [OW-1:0] lpf_output_real;
    logic [OW-1:0] lpf_output_imag;
    logic          busy;

    always #5 clock = ~clock;

    lpf_seq dut (
        .clock             (clock),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .sig_baseband_real (sig_baseband_real),
        .sig_baseband_imag (sig_baseband_imag),
        .coef_wr_en        (coef_wr_en),
        .coef_wr_addr      (coef_wr_addr),
        .coef_wr_data      (coef_wr_data),
        .coef_wr_err       (coef_wr_err),
        .out_valid         (out_valid),
        .lpf_output_real   (lpf_output_real),
        .lpf_output_imag   (lpf_output_imag),
        .busy              (busy)
    );

    typedef struct {
        logic signed [DW-1:0] in_i;
        logic signed [DW-1:0] in_q;
        logic signed [OW-1:0] exp_i;
        logic signed [OW-1:0] exp_q;
    } vec_t;

    vec_t vecs [40];
    int   total = 0;
    int   bad   = 0;

    localparam logic [DW-1:0] JUNK = 22'h15555;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(addr);
        coef_wr_data = CW'(data);
        @(negedge clock);
        coef_wr_en = 1'b0;
    endtask

    // mode 0: c[k]=k+1, 1: all 1, 2: all 2047
    task automatic load_coefs(input int mode);
        for (int k = 0; k < NTAPS; k++) begin
            write_coef(k, (mode == 0) ? k + 1 : (mode == 1) ? 1 : 2047);
        end
    endtask

    task automatic send_one(input logic signed [DW-1:0] si, input logic signed [DW-1:0] sq,
                            input bit inj_busy, input bit inj_idle,
                            output logic signed [OW-1:0] ri, output logic signed [OW-1:0] rq);
        int lat;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        check("ready_before_send", in_ready, 1);
        in_valid          = 1'b1;
        sig_baseband_real = si;
        sig_baseband_imag = sq;
        if (inj_idle) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = AW'(5);
            coef_wr_data = CW'(7);
        end
        @(negedge clock);
        in_valid          = 1'b0;
        coef_wr_en        = 1'b0;
        sig_baseband_real = JUNK;
        sig_baseband_imag = JUNK;
        lat = 1;
        check("busy_in_mac", busy, 1);
        check("ready_in_mac", in_ready, 0);
        if (inj_idle) check("err_idle_write", coef_wr_err, 0);
        if (inj_busy) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = AW'(5);
            coef_wr_data = CW'(7);
            @(negedge clock);
            coef_wr_en = 1'b0;
            check("err_pulse", coef_wr_err, 1);
            @(negedge clock);
            check("err_once", coef_wr_err, 0);
            lat = 3;
        end
        while (!out_valid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        // lat counts edges from acceptance up to and including the output edge
        check("latency", lat - 1, 33);
        check("ready_with_valid", in_ready, 1);
        check("busy_with_valid", busy, 0);
        ri = $signed(lpf_output_real);
        rq = $signed(lpf_output_imag);
        @(negedge clock);
        check("valid_one_cycle", out_valid, 0);
        check("output_held", $signed(lpf_output_real), ri);
    endtask

    task automatic run_vectors(input string name, input int n, input bit inj_busy0,
                               input bit inj_idle0);
        logic signed [OW-1:0] ri, rq;
        for (int idx = 0; idx < n; idx++) begin
            send_one(vecs[idx].in_i, vecs[idx].in_q, inj_busy0 && idx == 0,
                     inj_idle0 && idx == 0, ri, rq);
            check($sformatf("%s_i[%0d]", name, idx), ri, vecs[idx].exp_i);
            check($sformatf("%s_q[%0d]", name, idx), rq, vecs[idx].exp_q);
        end
    endtask

    task automatic fill_impulse();
        for (int n = 0; n < 33; n++) begin
            vecs[n].in_i  = (n == 0) ? 22'sd1 : 22'sd0;
            vecs[n].in_q  = '0;
            vecs[n].exp_i = (n < 32) ? OW'(32 - n) : '0;
            vecs[n].exp_q = '0;
        end
    endtask

    // in_valid held high; mode 0 = DC step 100/-100, mode 1 = ramp j+1 / -(j+1)
    task automatic stream(input int mode, input int n);
        int sent, got, cyc, last_acc, low_run;
        longint s;
        sent = 0; got = 0; cyc = 0; last_acc = 0; low_run = 0;
        while (got < n && cyc < n * 34 + 100) begin
            if (in_ready) begin
                if (low_run > 0) check("ready_low_run", low_run, 33);
                low_run = 0;
                if (sent < n) begin
                    if (sent > 0) check("accept_spacing", cyc - last_acc, 34);
                    last_acc          = cyc;
                    in_valid          = 1'b1;
                    sig_baseband_real = (mode == 0) ? 22'sd100 : DW'(sent + 1);
                    sig_baseband_imag = (mode == 0) ? -22'sd100 : -DW'(sent + 1);
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                low_run++;
                sig_baseband_real = JUNK;
                sig_baseband_imag = JUNK;
            end
            if (out_valid) begin
                s = 0;
                for (int j = (got > 31 ? got - 31 : 0); j <= got; j++) begin
                    s += (mode == 0) ? 100 : j + 1;
                end
                check($sformatf("stream%0d_i[%0d]", mode, got), $signed(lpf_output_real), s);
                check($sformatf("stream%0d_q[%0d]", mode, got), $signed(lpf_output_imag), -s);
                got++;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_complete", got, n);
    endtask

    initial begin
        logic signed [OW-1:0] ri, rq;
        int stray;
        rst = 1'b1; in_valid = 1'b0; coef_wr_en = 1'b0;
        coef_wr_addr = '0; coef_wr_data = '0;
        sig_baseband_real = '0; sig_baseband_imag = '0;
        @(negedge clock);
        do_reset();

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_coef_wr_err", coef_wr_err, 0);
        check("rst_out_real", lpf_output_real, 0);
        check("rst_out_imag", lpf_output_imag, 0);

        // impulse response with c[k]=k+1
        load_coefs(0);
        fill_impulse();
        run_vectors("impulse", 33, 0, 0);

        // saturation on every result: one tap alone already exceeds the range
        do_reset();
        load_coefs(2);
        for (int n = 0; n < 34; n++) begin
            vecs[n].in_i  = 22'sh1FFFFF;
            vecs[n].in_q  = 22'sh200000;
            vecs[n].exp_i = 32'sh7FFFFFFF;
            vecs[n].exp_q = 32'sh80000000;
        end
        run_vectors("sat", 34, 0, 0);

        // write c[5]=7 during MAC is dropped; c[5] seen 26 samples after an impulse
        do_reset();
        write_coef(31, 1);
        for (int n = 0; n < 27; n++) begin
            vecs[n].in_i  = (n == 0) ? 22'sd1 : 22'sd0;
            vecs[n].in_q  = '0;
            vecs[n].exp_i = (n == 0) ? 32'sd1 : 32'sd0;
            vecs[n].exp_q = '0;
        end
        run_vectors("busywr", 27, 1, 0);

        // same write in IDLE, on the acceptance edge, takes effect
        do_reset();
        write_coef(31, 1);
        vecs[26].exp_i = 32'sd7;
        run_vectors("idlewr", 27, 0, 1);

        // reset at tap 10 discards the computation and clears everything
        load_coefs(0);
        in_valid          = 1'b1;
        sig_baseband_real = 22'sd5;
        sig_baseband_imag = 22'sd3;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_real", lpf_output_real, 0);
        check("midrst_out_imag", lpf_output_imag, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        stray = 0;
        for (int k = 0; k < NTAPS; k++) begin
            write_coef(k, k + 1);
            if (out_valid) stray++;
        end
        check("midrst_no_stray_valid", stray, 0);
        fill_impulse();
        run_vectors("impulse2", 33, 0, 0);

        // DC step with in_valid held high
        do_reset();
        load_coefs(1);
        stream(0, 33);

        // ramp across the wr_ptr wrap with in_valid held high
        do_reset();
        load_coefs(1);
        stream(1, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpf_seq.md
# lpf_seq

Time-multiplexed sequencer for the 32-tap complex low-pass filter in the demodulator chain. It accepts one baseband I/Q sample per valid/ready handshake and stores it in a circular sample buffer. It then drives a single shared MAC per channel over all 32 taps and emits one registered, saturated I/Q result per input sample. It also owns the coefficient bank and gates coefficient writes so they never land mid-computation.

## Interface
- NTAPS, 32: number of taps. Power of two.
- DW, 22: input sample width, signed.
- CW, 12: coefficient width, signed.
- OW, 32: output width, signed, saturated.
- clock  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a sample is present on the input buses.
- in_ready  out  1  block can accept a sample. High only in IDLE.
- sig_baseband_real  in  DW  I sample.
- sig_baseband_imag  in  DW  Q sample.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  log2(NTAPS)  coefficient index.
- coef_wr_data  in  CW  coefficient value.
- coef_wr_err  out  1  one-cycle pulse when a write is dropped.
- out_valid  out  1  one-cycle pulse when a new result is present.
- lpf_output_real  out  OW  filtered I. Held between pulses.
- lpf_output_imag  out  OW  filtered Q. Held between pulses.
- busy  out  1  high in MAC or DONE.

## Operation
- Filter definition: y[n] = sum over k=0..31 of c[k]·x[n-31+k]. c[31] multiplies the newest sample; c[0] multiplies the oldest. All 32 taps are used.
- The I and Q channels use the same coefficients and are computed in parallel.
- States:
  - IDLE: in_ready=1. When in_valid=1, write the sample at wr_ptr, advance wr_ptr (wraps mod 32), clear the accumulators, set tap=0, go to MAC.
  - MAC: each cycle, acc += c[tap]·buf[(wr_ptr+tap) mod 32], then tap++. Because wr_ptr has already advanced, wr_ptr+0 addresses the oldest sample. After tap=31, go to DONE.
  - DONE: load the saturated accumulators into the output registers, pulse out_valid, go to IDLE.
- Arithmetic:
  - Each product is CW+DW=34 bits, signed.
  - Accumulator is 39 bits, signed; it cannot overflow for 32 taps.
  - Output saturates to [-2^31, 2^31-1].
- Coefficient writes:
  - In IDLE: accepted, effective on the next edge. Visible to a sample accepted on that same edge.
  - In MAC or DONE: dropped, and coef_wr_err pulses on the following cycle.
- Reset (including mid-MAC): state=IDLE, wr_ptr=0, tap=0, sample buffer and all coefficients cleared to 0, accumulators 0. A computation in flight is discarded with no out_valid.
- Output reset values: in_ready=1 (once in IDLE), out_valid=0, busy=0, coef_wr_err=0, lpf_output_real/imag=0.
- Warm-up: the first 31 results include zero history from the cleared buffer. No separate start flag.

## Timing
- E0 is the acceptance edge (in_valid & in_ready).
- Edges E1..E32 perform taps 0..31.
- Edge E33 registers the outputs. out_valid and in_ready are both high in the cycle after E33.
- Earliest next acceptance is E34. Throughput is 1 sample per 34 cycles; latency is 33 cycles.
- in_valid held high continuously: accepted exactly every 34 cycles. The sample bus is sampled only at the acceptance edge.
- in_valid together with coef_wr_en in IDLE: both take effect, and the new coefficient is used.
- wr_ptr wrap 31→0 is seamless, with no bubble.

## Structure
- Package lpf_pkg holds:
  - NTAPS, DW, CW, OW, ACCW=39;
  - the state enum {IDLE, MAC, DONE};
  - a saturation function (ACCW→OW).
- Sub-module lpf_mac: one signed multiply-accumulate with synchronous clear. Instantiated twice, once for I and once for Q.
- lpf_seq contains:
  - the FSM;
  - the tap counter and wr_ptr;
  - the 32×DW I/Q sample buffer;
  - the 32×CW coefficient registers.

## Test plan
- Impulse response:
  - Stimulus: c[k]=k+1; feed I=1, then zeros; Q=0.
  - Required: successive lpf_output_real = 32, 31, …, 1, then 0. Q is always 0.
- DC step:
  - Stimulus: all c=1; I=100, Q=-100 continuously.
  - Required: the n-th result (n from 0) is I=100(n+1), Q=-100(n+1), settling at 3200 / -3200 from n=31.
- Saturation:
  - Stimulus: all c=2047; I=2097151, Q=-2097152 for 32+ samples.
  - Required: I=2147483647, Q=-2147483648.
- Write while busy:
  - Stimulus: during MAC, write c[5]=7.
  - Required: coef_wr_err pulses once and c[5] is unchanged. The same write in IDLE takes effect.
- Reset mid-MAC:
  - Stimulus: assert rst at tap 10.
  - Required: no out_valid, outputs 0, in_ready=1 in the first cycle after rst deasserts. The next impulse reproduces the impulse-response scenario exactly.
- Handshake:
  - Stimulus: in_valid held high.
  - Required: in_ready low for 33 cycles, high for 1 cycle; acceptances spaced 34 cycles apart; no sample lost or duplicated across the wr_ptr wrap.
